mcs4_addr_stack: RTL
====================

Name: mcs4_addr_stack

Overview:
- Parametrised program-address unit for the MCS-4 CPU family. It holds the program counter and the subroutine return stack in one register file, in the 4004 style: the active level is the PC.
- It serialises the fetch address onto the 4-bit bus during A1..A3 and post-increments during M1.
- Commands are sampled and applied at X3.
- Successor to the fixed 4-level, 12-bit address logic inside the CPU core. Adds configurable depth and width (4004: 4 levels; 4040: 8 levels), sticky overflow/underflow error flags and a depth counter.

Parameters:
- STACK_DEPTH, 4, total address registers including the active PC level; must be ≥2.
- ADDR_NIBBLES, 3, address width in 4-bit characters; AW = 4*ADDR_NIBBLES.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous, active-low reset.
- icyc  in  3  instruction cycle from the timing generator: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
- cmd  in  3  address command, sampled only when icyc==X3: NONE=0, JUMP=1, JPAGE=2, CALL=3, RET=4; values 5..7 are treated as NONE.
- tgt  in  AW  jump/call target, sampled with cmd.
- clr_err  in  1  clears the sticky error flags.
- addr_nib  out  4  address character for the bus.
- addr_nib_vld  out  1  high when icyc is A1, A2 or A3.
- pc  out  AW  current active level, stack[sp].
- depth  out  clog2(STACK_DEPTH)  count of outstanding calls.
- ovf  out  1  sticky: call overflow occurred.
- unf  out  1  sticky: return underflow occurred.

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - sp, all stack entries, pc_snap, depth, ovf and unf all go to 0.
  - Output values: addr_nib=0, pc=0, ovf=0, unf=0, depth=0. addr_nib_vld still follows icyc.
  - Reset mid-instruction discards any pending cmd.
- pc is combinational from stack[sp]. No other combinational path from inputs to pc.
- Address serialisation:
  - pc_snap is loaded with the post-X3 PC value on the edge where icyc==X3.
  - addr_nib is a combinational select by icyc: A1 gives pc_snap[3:0], A2 gives pc_snap[7:4], A3 gives pc_snap[11:8]. For ADDR_NIBBLES>3, An continues with successive nibbles, and icyc values A1..A3 cover nibbles 0..2 only.
  - Any other icyc value drives addr_nib to 0.
- Increment: on the edge where icyc==M1, stack[sp] <= stack[sp]+1 modulo 2^AW. Wraps from all-ones to 0 with no flag.
- Commands, applied on the edge where icyc==X3. These act on the already-incremented PC.
  - JUMP: stack[sp] <= tgt.
  - JPAGE: stack[sp][7:0] <= tgt[7:0]; upper bits are kept. An instruction at the last byte of a page therefore jumps into the next page (4004 end-of-page rule).
  - CALL:
    - sp <= (sp==STACK_DEPTH-1) ? 0 : sp+1, and stack[new sp] <= tgt. The return address stays in the old level.
    - If depth==STACK_DEPTH-1, ovf is set, depth is held, and the oldest entry is overwritten (hardware wrap, matching silicon).
    - Otherwise depth increments.
  - RET:
    - sp <= (sp==0) ? STACK_DEPTH-1 : sp-1.
    - If depth==0, unf is set and depth stays 0; otherwise depth decrements.
    - The popped level is not cleared.
  - NONE: no change.
- Sticky flags:
  - clr_err clears ovf/unf on any edge.
  - If clr_err coincides with a new set event, set wins.
- Simultaneity: the M1 increment and an X3 command can never coincide. cmd/tgt are ignored outside X3.
- Bus timing: there is no handshake; the timing generator guarantees one icyc value per clk.

Optional Feature:
- Macro: MCS4_STACK_PEEK_EN.
- With the macro defined, two extra ports are added:
  - peek_idx  in  clog2(STACK_DEPTH)  index of the stack entry to read.
  - peek_addr  out  AW  value of stack[peek_idx], combinational; debug readback for the PYNQ host.
  - The peek path has no side effects on sp, depth or flags.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then run 3 instruction cycles with cmd=NONE → addr_nib sequence A1/A2/A3 = 0,0,0 then 1,0,0 then 2,0,0; pc reads 3 after the third M1.
- JUMP tgt=0x1FE at X3, then 2 NONE cycles → bus shows E,F,1 then F,F,1; pc=0x200 after the next M1 (page carry).
- pc=0x2FF before M1, then JPAGE tgt=0x034 → pc=0x334; bus shows 4,3,3.
- pc=0x100 before M1, CALL tgt=0x400, then RET → after CALL pc=0x400, depth=1; after RET pc=0x101, depth=0, no flags.
- STACK_DEPTH=4: 4 consecutive CALLs with targets 0x010, 0x020, 0x030, 0x040 → ovf=1 after the 4th, depth=3, pc=0x040. Then 4 RETs → the last RET sets unf=1.
- ovf=1 with clr_err pulsed alone → ovf=0. clr_err held during an overflowing CALL → ovf=1.
- With MCS4_STACK_PEEK_EN after the CALL test: peek_idx=0 → 0x101; no state change.

Source files
------------

// File: rtl/mcs4_addr_stack_if.sv
// mcs4_addr_stack bus bundle: timing/command inputs and address/status outputs.
// MCS4_STACK_PEEK_EN adds the peek_idx/peek_addr debug readback pair.
interface mcs4_addr_stack_if #(
  parameter int STACK_DEPTH  = 4,
  parameter int ADDR_NIBBLES = 3
);
  localparam int AW = 4 * ADDR_NIBBLES;
  localparam int DW = $clog2(STACK_DEPTH);

  logic [2:0]    icyc;
  logic [2:0]    cmd;
  logic [AW-1:0] tgt;
  logic          clr_err;
  logic [3:0]    addr_nib;
  logic          addr_nib_vld;
  logic [AW-1:0] pc;
  logic [DW-1:0] depth;
  logic          ovf;
  logic          unf;
`ifdef MCS4_STACK_PEEK_EN
  logic [DW-1:0] peek_idx;
  logic [AW-1:0] peek_addr;
`endif

  modport master (
`ifdef MCS4_STACK_PEEK_EN
    output peek_idx,
    input  peek_addr,
`endif
    output icyc,
    output cmd,
    output tgt,
    output clr_err,
    input  addr_nib,
    input  addr_nib_vld,
    input  pc,
    input  depth,
    input  ovf,
    input  unf
  );

  modport slave (
`ifdef MCS4_STACK_PEEK_EN
    input  peek_idx,
    output peek_addr,
`endif
    input  icyc,
    input  cmd,
    input  tgt,
    input  clr_err,
    output addr_nib,
    output addr_nib_vld,
    output pc,
    output depth,
    output ovf,
    output unf
  );
endinterface

// File: rtl/mcs4_addr_stack.sv
// MCS-4 program counter + return stack; the active level stack[sp] is the PC.
// Optional MCS4_STACK_PEEK_EN: combinational debug readback of any entry.
module mcs4_addr_stack #(
  parameter int STACK_DEPTH  = 4,
  parameter int ADDR_NIBBLES = 3
) (
  input logic             clk,
  input logic             rst_n,
  mcs4_addr_stack_if.slave bus
);
  localparam int AW = 4 * ADDR_NIBBLES;
  localparam int DW = $clog2(STACK_DEPTH);
  localparam logic [DW-1:0] TOP = DW'(STACK_DEPTH - 1);

  localparam logic [2:0] A1 = 3'd0;
  localparam logic [2:0] A2 = 3'd1;
  localparam logic [2:0] A3 = 3'd2;
  localparam logic [2:0] M1 = 3'd3;
  localparam logic [2:0] X3 = 3'd7;

  localparam logic [2:0] C_JUMP  = 3'd1;
  localparam logic [2:0] C_JPAGE = 3'd2;
  localparam logic [2:0] C_CALL  = 3'd3;
  localparam logic [2:0] C_RET   = 3'd4;

  logic [AW-1:0] stk [STACK_DEPTH];
  logic [DW-1:0] sp, sp_n;
  logic [DW-1:0] dep, dep_n;
  logic          ovf_q, ovf_n;
  logic          unf_q, unf_n;
  logic [AW-1:0] snap, snap_n;
  logic [AW-1:0] pc_cur;
  logic          wr_en;
  logic [DW-1:0] wr_idx;
  logic [AW-1:0] wr_val;

  assign pc_cur = stk[sp];

  // Next-state: M1 increment, X3 command decode, sticky flags, snapshot.
  always_comb begin
    sp_n   = sp;
    dep_n  = dep;
    ovf_n  = ovf_q & ~bus.clr_err;
    unf_n  = unf_q & ~bus.clr_err;
    wr_en  = 1'b0;
    wr_idx = sp;
    wr_val = pc_cur;
    snap_n = snap;
    unique case (1'b1)
      (bus.icyc == M1): begin
        wr_en  = 1'b1;
        wr_val = pc_cur + AW'(1);
      end
      (bus.icyc == X3): begin
        case (bus.cmd)
          C_JUMP: begin
            wr_en  = 1'b1;
            wr_val = bus.tgt;
          end
          C_JPAGE: begin
            wr_en  = 1'b1;
            wr_val = {pc_cur[AW-1:8], bus.tgt[7:0]};
          end
          C_CALL: begin
            sp_n   = (sp == TOP) ? '0 : sp + DW'(1);
            wr_en  = 1'b1;
            wr_idx = sp_n;
            wr_val = bus.tgt;
            if (dep == TOP) ovf_n = 1'b1;
            else            dep_n = dep + DW'(1);
          end
          C_RET: begin
            sp_n = (sp == '0) ? TOP : sp - DW'(1);
            if (dep == '0) unf_n = 1'b1;
            else           dep_n = dep - DW'(1);
          end
          default: ;
        endcase
        snap_n = wr_en ? wr_val : stk[sp_n];
      end
      default: ;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp    <= '0;
      dep   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      snap  <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else begin
      sp    <= sp_n;
      dep   <= dep_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
      snap  <= snap_n;
      if (wr_en) stk[wr_idx] <= wr_val;
    end
  end

  // Bus character select from the snapshot taken at X3.
  always_comb begin
    bus.addr_nib = 4'h0;
    case (bus.icyc)
      A1:      bus.addr_nib = snap[3:0];
      A2:      bus.addr_nib = snap[7:4];
      A3:      bus.addr_nib = snap[11:8];
      default: bus.addr_nib = 4'h0;
    endcase
  end

  assign bus.addr_nib_vld = (bus.icyc <= A3);
  assign bus.pc           = pc_cur;
  assign bus.depth        = dep;
  assign bus.ovf          = ovf_q;
  assign bus.unf          = unf_q;

`ifdef MCS4_STACK_PEEK_EN
  assign bus.peek_addr = stk[bus.peek_idx];
`endif

endmodule
